// File: rtl/loop_acc.sv
// -----------------------------------------------------------------------------
// loop_acc
//
// Accumulates the index beats of one loop pass coming from an upstream loop
// counter. For each pass it produces the sum of the indices, the number of
// beats, the largest (unsigned) index and a sticky overflow flag. The result
// is then held for a downstream consumer with a valid/ready handshake.
//
// Parameters
//   W   width of an index beat
//   SW  width of the accumulated sum (must be >= W)
//   CW  width of the beat count
//
// Ports
//   clk        single clock, rising-edge
//   rst        asynchronous, active-high reset
//   in_data    loop index from the upstream counter
//   in_next    beat valid
//   in_last    final beat of the pass (qualified by in_next)
//   in_en      ready to upstream; the counter advances only while high
//   out_sum    sum of the indices of the completed pass
//   out_cnt    number of beats in the completed pass
//   out_max    largest unsigned index in the completed pass
//   out_ovf    sum or count wrapped during the completed pass
//   out_valid  a result is pending
//   out_ready  downstream accepts the pending result
//   busy       a pass is partially accumulated
//
// Operation
//   IDLE : nothing pending, nothing accumulated
//   ACC  : part of a pass is accumulated, no result pending
//   HOLD : a completed result is presented on out_*
//   A beat accepted in IDLE, or in HOLD while the result is being taken,
//   starts a new pass. The beat carrying in_last loads out_* with the
//   accumulator values including that beat, on the same edge.
// -----------------------------------------------------------------------------
module loop_acc #(
   parameter int W  = 32,
   parameter int SW = 48,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  in_data,
   input  logic          in_next,
   input  logic          in_last,
   output logic          in_en,
   output logic [SW-1:0] out_sum,
   output logic [CW-1:0] out_cnt,
   output logic [W-1:0]  out_max,
   output logic          out_ovf,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Unsigned maximum of two indices.
   function automatic logic [W-1:0] umax(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Sum plus zero-extended index; the MSB of the result is the carry-out.
   function automatic logic [SW:0] sum_add(input logic [SW-1:0] s,
                                           input logic [W-1:0]  d);
      return {1'b0, s} + (SW+1)'(d);
   endfunction

   // Count plus one; the MSB of the result is the carry-out.
   function automatic logic [CW:0] cnt_inc(input logic [CW-1:0] c);
      return {1'b0, c} + (CW+1)'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t        state_q, state_d;

   logic [SW-1:0] acc_sum_q, acc_sum_d;
   logic [CW-1:0] acc_cnt_q, acc_cnt_d;
   logic [W-1:0]  acc_max_q, acc_max_d;
   logic          acc_ovf_q, acc_ovf_d;

   logic [SW-1:0] out_sum_q, out_sum_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [W-1:0]  out_max_q, out_max_d;
   logic          out_ovf_q, out_ovf_d;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic          hold;
   logic          accept;
   logic          first;

   assign hold      = (state_q == HOLD);
   assign out_valid = hold;
   assign busy      = (state_q == ACC);

   // Ready depends only on registered state and out_ready, never on in_next,
   // so upstream can drive in_next from in_en without a combinational loop.
   assign in_en     = !hold | out_ready;
   assign accept    = in_next & in_en;

   // Anything other than ACC means the accepted beat opens a new pass. In HOLD
   // an accepted beat implies out_ready, so the pending result is taken.
   assign first     = (state_q != ACC);

   // ---------------------------------------------------------------------------
   // Accumulator update for the beat presented this cycle
   // ---------------------------------------------------------------------------
   logic [SW:0]   sum_ext;
   logic [CW:0]   cnt_ext;
   logic [SW-1:0] new_sum;
   logic [CW-1:0] new_cnt;
   logic [W-1:0]  new_max;
   logic          new_ovf;

   assign sum_ext = sum_add(acc_sum_q, in_data);
   assign cnt_ext = cnt_inc(acc_cnt_q);

   always_comb begin
      new_sum = sum_ext[SW-1:0];
      new_cnt = cnt_ext[CW-1:0];
      new_max = umax(acc_max_q, in_data);
      new_ovf = acc_ovf_q | sum_ext[SW] | cnt_ext[CW];
      if (first) begin
         new_sum = SW'(in_data);
         new_cnt = CW'(1);
         new_max = in_data;
         new_ovf = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      acc_sum_d = acc_sum_q;
      acc_cnt_d = acc_cnt_q;
      acc_max_d = acc_max_q;
      acc_ovf_d = acc_ovf_q;
      out_sum_d = out_sum_q;
      out_cnt_d = out_cnt_q;
      out_max_d = out_max_q;
      out_ovf_d = out_ovf_q;

      if (accept) begin
         acc_sum_d = new_sum;
         acc_cnt_d = new_cnt;
         acc_max_d = new_max;
         acc_ovf_d = new_ovf;
         if (in_last) begin
            // Result is loaded on the same edge that takes the last beat.
            out_sum_d = new_sum;
            out_cnt_d = new_cnt;
            out_max_d = new_max;
            out_ovf_d = new_ovf;
            state_d   = HOLD;
         end else begin
            state_d   = ACC;
         end
      end else if (hold && out_ready) begin
         state_d = IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_sum_q <= '0;
         acc_cnt_q <= '0;
         acc_max_q <= '0;
         acc_ovf_q <= 1'b0;
         out_sum_q <= '0;
         out_cnt_q <= '0;
         out_max_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_sum_q <= acc_sum_d;
         acc_cnt_q <= acc_cnt_d;
         acc_max_q <= acc_max_d;
         acc_ovf_q <= acc_ovf_d;
         out_sum_q <= out_sum_d;
         out_cnt_q <= out_cnt_d;
         out_max_q <= out_max_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out_sum = out_sum_q;
   assign out_cnt = out_cnt_q;
   assign out_max = out_max_q;
   assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_loop_acc.sv
module tb_loop_acc;

   logic        clk;
   logic        rst;

   // Default-parameter instance
   logic [31:0] in_data;
   logic        in_next, in_last, in_en, out_ovf, out_valid, out_ready, busy;
   logic [47:0] out_sum;
   logic [15:0] out_cnt;
   logic [31:0] out_max;

   // Narrow instance for wrap/overflow cases
   logic [7:0]  n_data;
   logic        n_next, n_last, n_en, n_ovf, n_valid, n_ready, n_busy;
   logic [7:0]  n_sum;
   logic [3:0]  n_cnt;
   logic [7:0]  n_max;

   int checks;
   int failures;

   loop_acc dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_next(in_next), .in_last(in_last), .in_en(in_en),
      .out_sum(out_sum), .out_cnt(out_cnt), .out_max(out_max), .out_ovf(out_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   loop_acc #(.W(8), .SW(8), .CW(4)) dut_n (
      .clk(clk), .rst(rst),
      .in_data(n_data), .in_next(n_next), .in_last(n_last), .in_en(n_en),
      .out_sum(n_sum), .out_cnt(n_cnt), .out_max(n_max), .out_ovf(n_ovf),
      .out_valid(n_valid), .out_ready(n_ready), .busy(n_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        nxt;
      logic        lst;
      logic        rdy;
      logic [31:0] d;
      logic        e_en;    // in_en before the edge
      logic        e_vld;   // after the edge
      logic        e_busy;
      logic [47:0] e_sum;
      logic [15:0] e_cnt;
      logic [31:0] e_max;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic nxt, logic lst, logic rdy, logic [31:0] d,
                               logic e_en, logic e_vld, logic e_busy,
                               logic [47:0] e_sum, logic [15:0] e_cnt,
                               logic [31:0] e_max, logic e_ovf);
      vec_t v;
      v.nxt = nxt; v.lst = lst; v.rdy = rdy; v.d = d;
      v.e_en = e_en; v.e_vld = e_vld; v.e_busy = e_busy;
      v.e_sum = e_sum; v.e_cnt = e_cnt; v.e_max = e_max; v.e_ovf = e_ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle on the default instance: drive, check ready, clock, check outputs.
   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      in_next = v.nxt; in_last = v.lst; out_ready = v.rdy; in_data = v.d;
      #1;
      chk({tag, ".in_en"}, 64'(in_en), 64'(v.e_en));
      @(posedge clk); #1;
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(v.e_vld));
      chk({tag, ".busy"},      64'(busy),      64'(v.e_busy));
      chk({tag, ".out_sum"},   64'(out_sum),   64'(v.e_sum));
      chk({tag, ".out_cnt"},   64'(out_cnt),   64'(v.e_cnt));
      chk({tag, ".out_max"},   64'(out_max),   64'(v.e_max));
      chk({tag, ".out_ovf"},   64'(out_ovf),   64'(v.e_ovf));
   endtask

   task automatic beat(input logic nxt, input logic lst, input logic rdy, input logic [31:0] d);
      in_next = nxt; in_last = lst; out_ready = rdy; in_data = d;
      @(posedge clk); #1;
   endtask

   task automatic nbeat(input logic nxt, input logic lst, input logic rdy, input logic [7:0] d);
      n_next = nxt; n_last = lst; n_ready = rdy; n_data = d;
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      in_data = '0; in_next = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      n_data = '0; n_next = 1'b0; n_last = 1'b0; n_ready = 1'b0;

      // Reset state
      #2;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy",      64'(busy),      64'd0);
      chk("rst.in_en",     64'(in_en),     64'd1);
      chk("rst.out_sum",   64'(out_sum),   64'd0);
      chk("rst.out_cnt",   64'(out_cnt),   64'd0);
      chk("rst.n_in_en",   64'(n_en),      64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst.in_en", 64'(in_en), 64'd1);

      //          nxt  lst  rdy  data          en   vld  busy sum            cnt  max           ovf
      // indices 0..4, last on 4
      vecs.push_back(mk(1, 0, 1, 0,            1, 0, 1, 0,  0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1,            1, 0, 1, 0,  0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 2,            1, 0, 1, 0,  0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 3,            1, 0, 1, 0,  0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 4,            1, 1, 0, 10, 5, 4, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 0, 10, 5, 4, 0));
      // single beat 7, downstream stalls 3 cycles
      vecs.push_back(mk(1, 1, 0, 7,            1, 1, 0, 7,  1, 7, 0));
      vecs.push_back(mk(1, 1, 0, 99,           0, 1, 0, 7,  1, 7, 0));
      vecs.push_back(mk(1, 1, 0, 99,           0, 1, 0, 7,  1, 7, 0));
      vecs.push_back(mk(1, 1, 0, 99,           0, 1, 0, 7,  1, 7, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 0, 7,  1, 7, 0));
      // back-to-back single-beat passes 3,9,2
      vecs.push_back(mk(1, 1, 1, 3,            1, 1, 0, 3,  1, 3, 0));
      vecs.push_back(mk(1, 1, 1, 9,            1, 1, 0, 9,  1, 9, 0));
      vecs.push_back(mk(1, 1, 1, 2,            1, 1, 0, 2,  1, 2, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 0, 2,  1, 2, 0));
      // gapped beats 1,0,0,1,0,1 on indices 1,2,3 (stray last while idle ignored)
      vecs.push_back(mk(1, 0, 1, 1,            1, 0, 1, 2,  1, 2, 0));
      vecs.push_back(mk(0, 1, 1, 55,           1, 0, 1, 2,  1, 2, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 1, 2,  1, 2, 0));
      vecs.push_back(mk(1, 0, 1, 2,            1, 0, 1, 2,  1, 2, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 1, 2,  1, 2, 0));
      vecs.push_back(mk(1, 1, 1, 3,            1, 1, 0, 6,  3, 3, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 0, 6,  3, 3, 0));
      // max not on the last beat; out_ready low during ACC keeps in_en high
      vecs.push_back(mk(1, 0, 1, 5,            1, 0, 1, 6,  3, 3, 0));
      vecs.push_back(mk(1, 0, 0, 9,            1, 0, 1, 6,  3, 3, 0));
      vecs.push_back(mk(1, 1, 1, 1,            1, 1, 0, 15, 3, 9, 0));
      // new pass started straight from HOLD; full-scale indices, no overflow in 48 bits
      vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFF, 1, 0, 1, 15, 3, 9, 0));
      vecs.push_back(mk(1, 1, 1, 32'hFFFF_FFFF, 1, 1, 0, 48'h1_FFFF_FFFE, 2, 32'hFFFF_FFFF, 0));
      vecs.push_back(mk(0, 0, 1, 0,            1, 0, 0, 48'h1_FFFF_FFFE, 2, 32'hFFFF_FFFF, 0));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Asynchronous reset after two beats of a pass
      beat(1, 0, 1, 1);
      beat(1, 0, 1, 2);
      chk("arst.busy_before", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst.busy",      64'(busy),      64'd0);
      chk("arst.out_valid", 64'(out_valid), 64'd0);
      chk("arst.out_sum",   64'(out_sum),   64'd0);
      chk("arst.out_max",   64'(out_max),   64'd0);
      chk("arst.in_en",     64'(in_en),     64'd1);
      in_next = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      beat(1, 0, 1, 5);
      beat(1, 1, 1, 6);
      chk("arst_pass.out_valid", 64'(out_valid), 64'd1);
      chk("arst_pass.out_sum",   64'(out_sum),   64'd11);
      chk("arst_pass.out_cnt",   64'(out_cnt),   64'd2);
      chk("arst_pass.out_max",   64'(out_max),   64'd6);
      beat(0, 0, 1, 0);

      // Narrow instance: sum wraps, 200+100 = 300 -> 44
      nbeat(1, 0, 1, 8'd200);
      nbeat(1, 1, 1, 8'd100);
      chk("sw8.out_valid", 64'(n_valid), 64'd1);
      chk("sw8.out_sum",   64'(n_sum),   64'd44);
      chk("sw8.out_ovf",   64'(n_ovf),   64'd1);
      chk("sw8.out_cnt",   64'(n_cnt),   64'd2);
      chk("sw8.out_max",   64'(n_max),   64'd200);

      // Next pass from HOLD clears the sticky overflow
      nbeat(1, 1, 1, 8'd10);
      chk("sw8_next.out_ovf", 64'(n_ovf), 64'd0);
      chk("sw8_next.out_sum", 64'(n_sum), 64'd10);

      // Count wraps: 16 beats into a 4-bit count -> 0 with overflow
      for (int i = 0; i < 16; i++) nbeat(1, (i == 15), 1, 8'd0);
      chk("cw4.out_cnt", 64'(n_cnt), 64'd0);
      chk("cw4.out_ovf", 64'(n_ovf), 64'd1);
      chk("cw4.out_sum", 64'(n_sum), 64'd0);

      // Reset in HOLD discards the pending result
      nbeat(1, 1, 0, 8'd33);
      chk("hold.n_valid", 64'(n_valid), 64'd1);
      chk("hold.n_en",    64'(n_en),    64'd0);
      #2 rst = 1'b1;
      #1;
      chk("hold_rst.n_valid", 64'(n_valid), 64'd0);
      chk("hold_rst.n_sum",   64'(n_sum),   64'd0);
      chk("hold_rst.n_en",    64'(n_en),    64'd1);
      n_next = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      nbeat(0, 0, 1, 8'd0);
      chk("hold_rst.n_valid_after", 64'(n_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/loop_acc.md
LOOP_ACC -- requirements
Module: loop_acc

Interface
REQ-001 Parameter W, default 32, is the width of the index data beat.
REQ-002 Parameter SW, default 48, is the width of the accumulated sum.
REQ-003 Parameter CW, default 16, is the width of the beat count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_data  input  W  loop index from the upstream loop counter.
REQ-007 in_next  input  1  beat valid; in_data is meaningful this cycle.
REQ-008 in_last  input  1  final beat of the current loop pass; qualified by in_next.
REQ-009 in_en  output  1  ready to the upstream counter; the upstream counter advances only when this is high.
REQ-010 out_sum  output  SW  sum of the indices of the completed pass.
REQ-011 out_cnt  output  CW  number of beats in the completed pass.
REQ-012 out_max  output  W  largest unsigned index in the completed pass.
REQ-013 out_ovf  output  1  sum or count overflowed during the completed pass.
REQ-014 out_valid  output  1  result is pending.
REQ-015 out_ready  input  1  downstream accepts the pending result.
REQ-016 busy  output  1  a pass is partially accumulated.

Function
REQ-017 A beat is accepted when in_next & in_en; in_data and in_last are ignored otherwise.
REQ-018 The block SHALL implement states IDLE, ACC and HOLD; out_valid SHALL be 1 exactly in HOLD, and busy SHALL be 1 exactly in ACC.
REQ-019 in_en SHALL be driven combinationally as !out_valid | out_ready, with no combinational dependency on in_next.
REQ-020 First beat (accepted in IDLE, or in HOLD together with out_ready): acc_sum=zero-extended in_data, acc_cnt=1, acc_max=in_data, acc_ovf=0.
REQ-021 Later beat in ACC: acc_sum+=in_data, acc_cnt+=1, acc_max=max(acc_max,in_data) unsigned.
- acc_sum wraps mod 2^SW and acc_cnt wraps mod 2^CW.
- Any carry-out of either SHALL set acc_ovf sticky until the pass ends.
REQ-022 Transitions on an accepted beat:
- with in_last: go to HOLD and load out_* with the updated accumulator values in the same edge.
- without in_last: go to ACC.
REQ-023 A single-beat pass (in_next & in_last on the first beat) SHALL yield out_sum=in_data, out_cnt=1, out_max=in_data, out_ovf=0.
REQ-024 Latency: out_valid SHALL rise on the clock edge that accepts the last beat, i.e. it is visible the cycle after that beat.
REQ-025 HOLD & out_ready & no accepted beat -> IDLE; out_valid falls on that edge.
REQ-026 HOLD & out_ready & accepted beat -> start a new pass per REQ-020/022; a new result with in_last stays in HOLD, so back-to-back single-beat passes sustain one result per cycle.
REQ-027 HOLD & !out_ready: in_en=0, and out_* SHALL remain stable until accepted.
REQ-028 In ACC, out_valid=0 and in_en=1; idle cycles (in_next=0) SHALL NOT alter the accumulators.
REQ-029 out_sum, out_cnt, out_max and out_ovf SHALL change only on the edge that loads a result; between results they hold their last value.

Reset
REQ-030 rst asserted SHALL immediately force state IDLE, out_valid=0, busy=0, out_sum=0, out_cnt=0, out_max=0, out_ovf=0 and all accumulators to 0.
REQ-031 in_en SHALL be 1 during and after reset.
REQ-032 Reset mid-pass or in HOLD SHALL discard partial and pending results without emitting them.

Verification
REQ-033 The bench SHALL cover: indices 0..4 with last on 4 and out_ready=1 -> one cycle later out_valid=1, out_sum=10, out_cnt=5, out_max=4, out_ovf=0.
REQ-034 The bench SHALL cover: single beat 7 with in_last, out_ready held 0 for 3 cycles -> in_en=0 for those cycles, outputs stable at sum 7/cnt 1/max 7, then returns to IDLE on accept.
REQ-035 The bench SHALL cover: back-to-back single-beat passes 3,9,2 with out_ready=1 -> three consecutive out_valid cycles with out_sum 3,9,2.
REQ-036 The bench SHALL cover: with SW=8, beats 200,100 last -> out_sum=44, out_ovf=1, out_cnt=2, out_max=200.
REQ-037 The bench SHALL cover: rst asserted asynchronously after 2 beats of a pass -> busy=0 without waiting for a clock edge, and the next pass 5,6 last -> out_sum=11, out_cnt=2.
REQ-038 The bench SHALL cover: in_next gapped (pattern 1,0,0,1,0,1 with last) on indices 1,2,3 -> out_sum=6, out_cnt=3.
